kernel_cc_start_fifo_ext: RTL

KERNEL_CC_START_FIFO_EXT -- requirements
Module: kernel_cc_start_fifo_ext

---
 rtl/kernel_cc_start_fifo_ext.sv | 84 ++++++++
 1 files changed

// File: rtl/kernel_cc_start_fifo_ext.sv
// kernel_cc_start_fifo_ext: first-word-fall-through FIFO built on a shift register, with
// registered occupancy, watermark, full/empty and sticky overflow/underflow flags.
module kernel_cc_start_fifo_ext #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow,
    input  logic                  if_err_clr
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  wr_off;
    logic                  rd_off;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;

    // Requests seen while reset is high are masked so they cannot touch storage.
    always_comb begin
        wr_off     = if_write & if_write_ce & ~reset;
        rd_off     = if_read & if_read_ce & ~reset;
        rd_acc     = rd_off & (count != '0);
        wr_acc     = wr_off & ((count != FULL_CNT) | rd_acc);
        ovf_set    = wr_off & (count == FULL_CNT) & ~rd_acc;
        unf_set    = rd_off & (count == '0);
        count_next = (wr_acc & ~rd_acc) ? count + 1'b1 :
                     (rd_acc & ~wr_acc) ? count - 1'b1 : count;
        rd_idx     = (count == '0) ? '0 : ADDR_WIDTH'(count - 1'b1);
    end

    // The oldest word sits at the top of the occupied region.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[0] <= if_din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count           <= '0;
            if_empty_n      <= 1'b0;
            if_full_n       <= 1'b1;
            if_almost_full  <= (AFULL_LVL <= 0);
            if_almost_empty <= (AEMPTY_LVL >= 0);
            if_overflow     <= 1'b0;
            if_underflow    <= 1'b0;
        end else begin
            count           <= count_next;
            if_empty_n      <= (count_next != '0);
            if_full_n       <= (count_next != FULL_CNT);
            if_almost_full  <= (int'(count_next) >= AFULL_LVL);
            if_almost_empty <= (int'(count_next) <= AEMPTY_LVL);
            if_overflow     <= ovf_set | (if_overflow & ~if_err_clr);
            if_underflow    <= unf_set | (if_underflow & ~if_err_clr);
        end
    end

    assign if_count = count;
    assign if_dout  = mem[rd_idx];
endmodule
